// File: rtl/codificador_seg7_if.sv
// Segment-pattern input and BCD word hand-off bundle for codificador_seg7.
// The master drives segment samples, clear and ack; the slave is the encoder.
interface codificador_seg7_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_in;
    logic                    seg_strobe;
    logic                    clear;
    logic                    value_ack;
    logic                    digit_valid;
    logic [3:0]              digit_bcd;
    logic                    digit_err;
    logic [4*NUM_DIGITS-1:0] bcd_value;
    logic                    value_valid;
    logic                    overrun;

    modport master (
        output seg_in, seg_strobe, clear, value_ack,
        input  digit_valid, digit_bcd, digit_err, bcd_value, value_valid, overrun
    );

    modport slave (
        input  seg_in, seg_strobe, clear, value_ack,
        output digit_valid, digit_bcd, digit_err, bcd_value, value_valid, overrun
    );
endinterface

// File: rtl/codificador_seg7.sv
// Active-low 7-segment pattern to BCD encoder with a stability qualifier and
// a multi-digit word assembler handed off through a valid/ack pair.
module codificador_seg7 #(
    parameter int STABLE_CYCLES = 4,
    parameter int NUM_DIGITS    = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    codificador_seg7_if.slave    bus
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int WW = 4 * NUM_DIGITS;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] PAT [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    logic [6:0]    last_q,  last_d;
    logic [SW-1:0] stab_q,  stab_d;
    logic          armed_q, armed_d;
    logic [WW-1:0] acc_q,   acc_d;
    logic [DW-1:0] dcount_q, dcount_d;
    logic          digit_valid_q, digit_valid_d;
    logic          digit_err_q,   digit_err_d;
    logic [3:0]    digit_bcd_q,   digit_bcd_d;
    logic [WW-1:0] bcd_value_q,   bcd_value_d;
    logic          value_valid_q, value_valid_d;
    logic          overrun_q,     overrun_d;

    logic [9:0]    hit;
    logic [3:0]    hit_digit;
    logic          found;
    logic          is_blank;
    logic          armed_eff;
    logic          qualify;
    logic          accept;
    logic          ack_eff;
    logic [WW-1:0] acc_shift;

    // One comparator per table entry; at most one can match.
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_match
            assign hit[gi] = (bus.seg_in == PAT[gi]);
        end
    endgenerate

    always_comb begin
        hit_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (hit[i]) hit_digit = 4'(i);
        end
    end

    assign found     = |hit;
    assign is_blank  = (bus.seg_in == BLANK);
    assign acc_shift = (acc_q << 4) | WW'(hit_digit);

    always_comb begin
        last_d        = last_q;
        stab_d        = stab_q;
        armed_d       = armed_q;
        acc_d         = acc_q;
        dcount_d      = dcount_q;
        digit_valid_d = 1'b0;
        digit_err_d   = 1'b0;
        digit_bcd_d   = digit_bcd_q;
        bcd_value_d   = bcd_value_q;
        value_valid_d = value_valid_q;
        overrun_d     = overrun_q;
        armed_eff     = armed_q;
        qualify       = 1'b0;

        if (bus.seg_strobe) begin
            if (bus.seg_in == last_q) begin
                stab_d = (stab_q == SW'(STABLE_CYCLES)) ? stab_q : stab_q + SW'(1);
            end else begin
                last_d    = bus.seg_in;
                stab_d    = SW'(1);
                armed_eff = 1'b1;
            end
            // Only the strobe that first reaches the threshold fires; armed blocks repeats.
            qualify = armed_eff && (stab_d == SW'(STABLE_CYCLES));
            armed_d = armed_eff && !qualify;
        end

        accept  = qualify && found;
        ack_eff = bus.value_ack && value_valid_q;

        if (qualify && !is_blank) begin
            digit_valid_d = 1'b1;
            digit_err_d   = !found;
            digit_bcd_d   = found ? hit_digit : 4'hF;
        end

        if (ack_eff) begin
            value_valid_d = 1'b0;
            overrun_d     = 1'b0;
        end

        if (bus.clear) begin
            acc_d    = '0;
            dcount_d = '0;
        end else if (accept) begin
            if (value_valid_q && !ack_eff) begin
                overrun_d = 1'b1;
            end else if (dcount_q == DW'(NUM_DIGITS - 1)) begin
                bcd_value_d   = acc_shift;
                value_valid_d = 1'b1;
                acc_d         = '0;
                dcount_d      = '0;
            end else begin
                acc_d    = acc_shift;
                dcount_d = dcount_q + DW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            last_q        <= BLANK;
            stab_q        <= '0;
            armed_q       <= 1'b1;
            acc_q         <= '0;
            dcount_q      <= '0;
            digit_valid_q <= 1'b0;
            digit_err_q   <= 1'b0;
            digit_bcd_q   <= 4'd0;
            bcd_value_q   <= '0;
            value_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            last_q        <= last_d;
            stab_q        <= stab_d;
            armed_q       <= armed_d;
            acc_q         <= acc_d;
            dcount_q      <= dcount_d;
            digit_valid_q <= digit_valid_d;
            digit_err_q   <= digit_err_d;
            digit_bcd_q   <= digit_bcd_d;
            bcd_value_q   <= bcd_value_d;
            value_valid_q <= value_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bus.digit_valid = digit_valid_q;
    assign bus.digit_err   = digit_err_q;
    assign bus.digit_bcd   = digit_bcd_q;
    assign bus.bcd_value   = bcd_value_q;
    assign bus.value_valid = value_valid_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_codificador_seg7.sv
// Bench for codificador_seg7: directed scenarios plus random segment traffic,
// every cycle compared against a digit-list reference model.
module tb_codificador_seg7;
    localparam int SC = 4;
    localparam int ND = 4;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    codificador_seg7_if #(.NUM_DIGITS(ND)) bus ();

    codificador_seg7 #(.STABLE_CYCLES(SC), .NUM_DIGITS(ND)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    logic [6:0] pat_tab [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: run length of the current pattern and a list of pending digits.
    logic [6:0]      m_last;
    int              m_run;
    int              m_digits[$];
    logic            m_vv, m_ovr, m_dv, m_err;
    logic [3:0]      m_bcd;
    logic [4*ND-1:0] m_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lookup(input logic [6:0] p);
        if (p == BLANK) return 10;
        for (int i = 0; i < 10; i++) if (pat_tab[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_last = BLANK; m_run = 0; m_digits.delete();
        m_vv = 0; m_ovr = 0; m_dv = 0; m_err = 0; m_bcd = 0; m_val = '0;
    endtask

    task automatic model_step(input logic [6:0] s, input logic stb, input logic clr, input logic ack);
        bit qual = 0;
        bit ack_eff, vv_old;
        int code, value;
        m_dv = 0; m_err = 0;
        if (stb) begin
            if (s == m_last) begin
                if (m_run <= SC) m_run++;
            end else begin
                m_last = s; m_run = 1;
            end
            qual = (m_run == SC);
        end
        code    = lookup(s);
        vv_old  = m_vv;
        ack_eff = ack && m_vv;
        if (qual && code != 10) begin
            m_dv  = 1;
            m_err = (code < 0);
            m_bcd = (code < 0) ? 4'hF : 4'(code);
        end
        if (ack_eff) begin m_vv = 0; m_ovr = 0; end
        if (clr) begin
            m_digits.delete();
        end else if (qual && code >= 0 && code <= 9) begin
            if (vv_old && !ack_eff) m_ovr = 1;
            else begin
                m_digits.push_back(code);
                if (m_digits.size() == ND) begin
                    value = 0;
                    foreach (m_digits[k]) value = value * 16 + m_digits[k];
                    m_val = (4*ND)'(value);
                    m_vv  = 1;
                    m_digits.delete();
                end
            end
        end
    endtask

    task automatic compare_all(input string ctx);
        chk({ctx, ".digit_valid"}, 32'(bus.digit_valid), 32'(m_dv));
        chk({ctx, ".digit_err"},   32'(bus.digit_err),   32'(m_err));
        chk({ctx, ".digit_bcd"},   32'(bus.digit_bcd),   32'(m_bcd));
        chk({ctx, ".value_valid"}, 32'(bus.value_valid), 32'(m_vv));
        chk({ctx, ".bcd_value"},   32'(bus.bcd_value),   32'(m_val));
        chk({ctx, ".overrun"},     32'(bus.overrun),     32'(m_ovr));
    endtask

    task automatic step(input logic [6:0] s, input logic stb, input logic clr, input logic ack);
        bus.seg_in = s; bus.seg_strobe = stb; bus.clear = clr; bus.value_ack = ack;
        @(posedge clk);
        model_step(s, stb, clr, ack);
        #1;
        compare_all("cycle");
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        repeat (n) step(p, 1'b1, 1'b0, 1'b0);
    endtask

    // Enters one digit followed by a blank separator; clear/ack ride on the qualifying strobe.
    task automatic enter(input int d, input logic clr_last, input logic ack_last);
        hold(pat_tab[d], SC - 1);
        step(pat_tab[d], 1'b1, clr_last, ack_last);
        hold(BLANK, SC);
        $display("digit %0d entered: value_valid=%0b bcd_value=%h overrun=%0b",
                 d, bus.value_valid, bus.bcd_value, bus.overrun);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.seg_in = 7'($urandom_range(0, 127));
        bus.seg_strobe = 1'b1; bus.clear = 1'b0; bus.value_ack = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        chk("rst.digit_valid", 32'(bus.digit_valid), 32'd0);
        chk("rst.digit_err",   32'(bus.digit_err),   32'd0);
        chk("rst.digit_bcd",   32'(bus.digit_bcd),   32'd0);
        chk("rst.value_valid", 32'(bus.value_valid), 32'd0);
        chk("rst.bcd_value",   32'(bus.bcd_value),   32'd0);
        chk("rst.overrun",     32'(bus.overrun),     32'd0);
        rst = 1'b0;
        $display("reset applied");
    endtask

    initial begin
        int pulses;
        logic [6:0] p;
        bus.seg_in = BLANK; bus.seg_strobe = 0; bus.clear = 0; bus.value_ack = 0;
        model_reset();
        do_reset();

        // Qualify timing: pulse appears with the 4th strobe's edge, then never again.
        hold(pat_tab[2], SC - 1);
        chk("qual.before", 32'(bus.digit_valid), 32'd0);
        step(pat_tab[2], 1'b1, 1'b0, 1'b0);
        chk("qual.pulse", 32'(bus.digit_valid), 32'd1);
        chk("qual.bcd",   32'(bus.digit_bcd),   32'd2);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(pat_tab[2], 1'b1, 1'b0, 1'b0);
            pulses += int'(bus.digit_valid);
        end
        chk("qual.no_repeat", 32'(pulses), 32'd0);
        $display("qualify timing: digit 2, %0d extra pulses", pulses);
        step(BLANK, 1'b0, 1'b1, 1'b0);

        // Word assembly and hand-off.
        enter(1, 0, 0); enter(9, 0, 0); enter(0, 0, 0); enter(7, 0, 0);
        chk("word.valid", 32'(bus.value_valid), 32'd1);
        chk("word.value", 32'(bus.bcd_value),   32'h1907);
        step(BLANK, 1'b0, 1'b0, 1'b1);
        chk("word.acked", 32'(bus.value_valid), 32'd0);

        // Error pattern: flagged, never accumulated.
        hold(7'b1111110, SC);
        chk("err.valid", 32'(bus.digit_valid), 32'd1);
        chk("err.flag",  32'(bus.digit_err),   32'd1);
        chk("err.bcd",   32'(bus.digit_bcd),   32'hF);
        hold(BLANK, SC);

        // Overrun, then ack on the same edge as the next digit.
        enter(1, 0, 0); enter(2, 0, 0); enter(3, 0, 0); enter(4, 0, 0);
        chk("ovr.word", 32'(bus.bcd_value), 32'h1234);
        enter(5, 0, 0);
        chk("ovr.set",  32'(bus.overrun),   32'd1);
        chk("ovr.keep", 32'(bus.bcd_value), 32'h1234);
        enter(6, 0, 1);
        chk("ovr.vv_clr",  32'(bus.value_valid), 32'd0);
        chk("ovr.flag_clr", 32'(bus.overrun),    32'd0);
        enter(7, 0, 0); enter(8, 0, 0); enter(9, 0, 0);
        chk("ovr.next_word", 32'(bus.bcd_value), 32'h6789);
        step(BLANK, 1'b0, 1'b0, 1'b1);

        // Clear on the same edge as the third digit.
        enter(3, 0, 0); enter(1, 0, 0); enter(4, 1, 0);
        chk("clr.no_word", 32'(bus.value_valid), 32'd0);
        enter(5, 0, 0); enter(6, 0, 0); enter(7, 0, 0); enter(8, 0, 0);
        chk("clr.word", 32'(bus.bcd_value), 32'h5678);
        step(BLANK, 1'b0, 1'b0, 1'b1);

        // Reset mid-word discards the partial word.
        enter(9, 0, 0); enter(8, 0, 0); enter(7, 0, 0);
        do_reset();
        enter(2, 0, 0); enter(4, 0, 0); enter(6, 0, 0);
        chk("rstmid.no_word", 32'(bus.value_valid), 32'd0);
        enter(8, 0, 0);
        chk("rstmid.word", 32'(bus.bcd_value), 32'h2468);
        step(BLANK, 1'b0, 1'b0, 1'b1);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            int sel = $urandom_range(0, 13);
            int len = $urandom_range(1, 7);
            if (sel < 10)       p = pat_tab[sel];
            else if (sel < 13)  p = BLANK;
            else                p = 7'($urandom_range(0, 127));
            for (int j = 0; j < len; j++) begin
                step(p, ($urandom % 4) != 0, ($urandom % 60) == 0, ($urandom % 5) == 0);
            end
            if (bus.digit_valid)
                $display("random digit: bcd=%h err=%0b value_valid=%0b", bus.digit_bcd, bus.digit_err, bus.value_valid);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
